// File: rtl/edge_bit_counter_cfg.sv
// Oversampling edge/bit counter for the UART receiver with run-time prescale and frame length.
// Define EBC_HOLD_ON_DONE_EN to freeze after frame_done until enable drops.
module edge_bit_counter_cfg #(
   parameter int PRESCALE_W = 6,
   parameter int BIT_CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [BIT_CNT_W-1:0]  frame_len,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic                  bit_done,
   output logic                  frame_done,
   output logic                  sample_en
);

   localparam logic [PRESCALE_W-1:0] PRE_MIN = PRESCALE_W'(4);
   localparam logic [PRESCALE_W-1:0] PRE_RST = PRESCALE_W'(8);
   localparam logic [BIT_CNT_W-1:0]  LEN_MIN = BIT_CNT_W'(1);
   localparam logic [BIT_CNT_W-1:0]  LEN_RST = BIT_CNT_W'(10);

   logic [PRESCALE_W-1:0] pre_l;
   logic [PRESCALE_W-1:0] half;
   logic [BIT_CNT_W-1:0]  frame_len_l;
   logic                  edge_wrap;
   logic                  last_bit;
   logic                  mid_bit;

   assign half      = pre_l >> 1;
   assign edge_wrap = (edge_cnt == pre_l - PRESCALE_W'(1));
   assign last_bit  = (bit_cnt == frame_len_l - BIT_CNT_W'(1));
   assign mid_bit   = (edge_cnt == half - PRESCALE_W'(1)) ||
                      (edge_cnt == half) ||
                      (edge_cnt == half + PRESCALE_W'(1));

   // Config is sampled only while idle, so a frame always runs with one consistent timing.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pre_l       <= PRE_RST;
         frame_len_l <= LEN_RST;
      end else if (!enable) begin
         pre_l       <= (prescale < PRE_MIN) ? PRE_MIN : prescale;
         frame_len_l <= (frame_len == '0) ? LEN_MIN : frame_len;
      end
   end

`ifdef EBC_HOLD_ON_DONE_EN
   logic held;

   always_ff @(posedge clk) begin
      if (!rst || !enable) begin
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         bit_done   <= 1'b0;
         frame_done <= 1'b0;
         held       <= 1'b0;
      end else if (held) begin
         bit_done   <= 1'b0;
         frame_done <= 1'b0;
      end else if (!edge_wrap) begin
         edge_cnt   <= edge_cnt + PRESCALE_W'(1);
         bit_done   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         edge_cnt <= '0;
         bit_done <= 1'b1;
         if (!last_bit) begin
            bit_cnt    <= bit_cnt + BIT_CNT_W'(1);
            frame_done <= 1'b0;
         end else begin
            // Parking at frame_len_l tells the deserializer the frame is complete.
            bit_cnt    <= frame_len_l;
            frame_done <= 1'b1;
            held       <= 1'b1;
         end
      end
   end

   assign sample_en = enable && !held && mid_bit;
`else
   always_ff @(posedge clk) begin
      if (!rst || !enable) begin
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         bit_done   <= 1'b0;
         frame_done <= 1'b0;
      end else if (!edge_wrap) begin
         edge_cnt   <= edge_cnt + PRESCALE_W'(1);
         bit_done   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         edge_cnt <= '0;
         bit_done <= 1'b1;
         if (!last_bit) begin
            bit_cnt    <= bit_cnt + BIT_CNT_W'(1);
            frame_done <= 1'b0;
         end else begin
            bit_cnt    <= '0;
            frame_done <= 1'b1;
         end
      end
   end

   assign sample_en = enable && mid_bit;
`endif

endmodule

// File: tb/tb_edge_bit_counter_cfg.sv
// Directed bench for edge_bit_counter_cfg; expectations follow EBC_HOLD_ON_DONE_EN when defined.
module tb_edge_bit_counter_cfg;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [5:0] prescale;
   logic [3:0] frame_len;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       bit_done;
   logic       frame_done;
   logic       sample_en;

   int errors = 0;
   int checks = 0;

   edge_bit_counter_cfg #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .prescale   (prescale),
      .frame_len  (frame_len),
      .edge_cnt   (edge_cnt),
      .bit_cnt    (bit_cnt),
      .bit_done   (bit_done),
      .frame_done (frame_done),
      .sample_en  (sample_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled 1 ns after the rising edge and inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; enable = 1'b1; prescale = 6'd8; frame_len = 4'd10;
      tick();
      tick();
      checks++; if (edge_cnt !== 6'd0)  begin errors++; $display("[TB] FAIL reset_edge_cnt: got %0d expected 0", edge_cnt); end
      checks++; if (bit_cnt !== 4'd0)   begin errors++; $display("[TB] FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
      checks++; if (bit_done !== 1'b0)  begin errors++; $display("[TB] FAIL reset_bit_done: got %b expected 0", bit_done); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
      checks++; if (sample_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_sample_en: got %b expected 0", sample_en); end
      rst = 1'b1; enable = 1'b0;
      tick();
   endtask

   task automatic test_frame_8x10();
      int e, b;
      logic bd, fd, se;
      prescale = 6'd8; frame_len = 4'd10; enable = 1'b0;
      tick();
      enable = 1'b1;
      for (int c = 1; c <= 82; c++) begin
         tick();
         e = c % 8; b = (c / 8) % 10; bd = (e == 0); fd = (c == 80); se = (e >= 3 && e <= 5);
`ifdef EBC_HOLD_ON_DONE_EN
         if (c >= 80) begin e = 0; b = 10; se = 1'b0; end
`endif
         checks++;
         if ({edge_cnt, bit_cnt, bit_done, frame_done, sample_en} !== {6'(e), 4'(b), bd, fd, se}) begin
            errors++;
            $display("[TB] FAIL frame_8x10 c=%0d: got edge=%0d bit=%0d bd=%b fd=%b se=%b, expected edge=%0d bit=%0d bd=%b fd=%b se=%b",
                     c, edge_cnt, bit_cnt, bit_done, frame_done, sample_en, e, b, bd, fd, se);
         end
      end
      enable = 1'b0;
      tick();
      checks++;
      if ({edge_cnt, bit_cnt, bit_done, frame_done} !== 12'd0) begin
         errors++;
         $display("[TB] FAIL frame_8x10_idle: got edge=%0d bit=%0d bd=%b fd=%b, expected all 0", edge_cnt, bit_cnt, bit_done, frame_done);
      end
   endtask

   task automatic test_config_latch();
      int e, b;
      logic bd, se;
      prescale = 6'd16; frame_len = 4'd11; enable = 1'b0;
      tick();
      enable = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 5) prescale = 6'd32;
         e = c % 16; b = c / 16; bd = (e == 0); se = (e >= 7 && e <= 9);
         checks++;
         if ({edge_cnt, bit_cnt, bit_done, frame_done, sample_en} !== {6'(e), 4'(b), bd, 1'b0, se}) begin
            errors++;
            $display("[TB] FAIL latch_16 c=%0d: got edge=%0d bit=%0d bd=%b fd=%b se=%b, expected edge=%0d bit=%0d bd=%b fd=0 se=%b",
                     c, edge_cnt, bit_cnt, bit_done, frame_done, sample_en, e, b, bd, se);
         end
      end
      enable = 1'b0;
      tick();
      checks++;
      if ({edge_cnt, bit_cnt, bit_done, frame_done, sample_en} !== 13'd0) begin
         errors++;
         $display("[TB] FAIL latch_idle: got edge=%0d bit=%0d bd=%b fd=%b se=%b, expected all 0", edge_cnt, bit_cnt, bit_done, frame_done, sample_en);
      end
      enable = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         e = c % 32; b = c / 32; bd = (e == 0); se = (e >= 15 && e <= 17);
         checks++;
         if ({edge_cnt, bit_cnt, bit_done, frame_done, sample_en} !== {6'(e), 4'(b), bd, 1'b0, se}) begin
            errors++;
            $display("[TB] FAIL latch_32 c=%0d: got edge=%0d bit=%0d bd=%b fd=%b se=%b, expected edge=%0d bit=%0d bd=%b fd=0 se=%b",
                     c, edge_cnt, bit_cnt, bit_done, frame_done, sample_en, e, b, bd, se);
         end
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_clamp();
      int e, b;
      logic bd, fd, se;
      prescale = 6'd2; frame_len = 4'd0; enable = 1'b0;
      tick();
      enable = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         e = c % 4; b = 0; bd = (e == 0); fd = (e == 0); se = (e >= 1 && e <= 3);
`ifdef EBC_HOLD_ON_DONE_EN
         if (c >= 4) begin e = 0; b = 1; bd = (c == 4); fd = (c == 4); se = 1'b0; end
`endif
         checks++;
         if ({edge_cnt, bit_cnt, bit_done, frame_done, sample_en} !== {6'(e), 4'(b), bd, fd, se}) begin
            errors++;
            $display("[TB] FAIL clamp c=%0d: got edge=%0d bit=%0d bd=%b fd=%b se=%b, expected edge=%0d bit=%0d bd=%b fd=%b se=%b",
                     c, edge_cnt, bit_cnt, bit_done, frame_done, sample_en, e, b, bd, fd, se);
         end
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_enable_drop();
      int e, b;
      logic bd, se;
      prescale = 6'd8; frame_len = 4'd10; enable = 1'b0;
      tick();
      enable = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         for (int c = 1; c <= ((pass == 0) ? 43 : 10); c++) begin
            tick();
            e = c % 8; b = c / 8; bd = (e == 0); se = (e >= 3 && e <= 5);
            checks++;
            if ({edge_cnt, bit_cnt, bit_done, frame_done, sample_en} !== {6'(e), 4'(b), bd, 1'b0, se}) begin
               errors++;
               $display("[TB] FAIL drop pass=%0d c=%0d: got edge=%0d bit=%0d bd=%b fd=%b se=%b, expected edge=%0d bit=%0d bd=%b fd=0 se=%b",
                        pass, c, edge_cnt, bit_cnt, bit_done, frame_done, sample_en, e, b, bd, se);
            end
         end
         if (pass == 0) begin
            enable = 1'b0;
            tick();
            checks++;
            if ({edge_cnt, bit_cnt, bit_done, frame_done, sample_en} !== 13'd0) begin
               errors++;
               $display("[TB] FAIL drop_clear: got edge=%0d bit=%0d bd=%b fd=%b se=%b, expected all 0", edge_cnt, bit_cnt, bit_done, frame_done, sample_en);
            end
            enable = 1'b1;
         end
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_frame();
      int e, b;
      logic bd, fd, se;
      prescale = 6'd16; frame_len = 4'd10; enable = 1'b0;
      tick();
      enable = 1'b1;
      for (int c = 1; c <= 117; c++) tick();
      checks++;
      if ({edge_cnt, bit_cnt} !== {6'd5, 4'd7}) begin
         errors++;
         $display("[TB] FAIL pre_reset_pos: got edge=%0d bit=%0d, expected edge=5 bit=7", edge_cnt, bit_cnt);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({edge_cnt, bit_cnt, bit_done, frame_done, sample_en} !== 13'd0) begin
         errors++;
         $display("[TB] FAIL mid_reset: got edge=%0d bit=%0d bd=%b fd=%b se=%b, expected all 0", edge_cnt, bit_cnt, bit_done, frame_done, sample_en);
      end
      rst = 1'b1;
      for (int c = 1; c <= 90; c++) begin
         tick();
         e = c % 8; b = (c / 8) % 10; bd = (e == 0); fd = (c == 80); se = (e >= 3 && e <= 5);
`ifdef EBC_HOLD_ON_DONE_EN
         if (c >= 80) begin e = 0; b = 10; bd = (c == 80); se = 1'b0; end
`endif
         checks++;
         if ({edge_cnt, bit_cnt, bit_done, frame_done, sample_en} !== {6'(e), 4'(b), bd, fd, se}) begin
            errors++;
            $display("[TB] FAIL post_reset c=%0d: got edge=%0d bit=%0d bd=%b fd=%b se=%b, expected edge=%0d bit=%0d bd=%b fd=%b se=%b",
                     c, edge_cnt, bit_cnt, bit_done, frame_done, sample_en, e, b, bd, fd, se);
         end
      end
      enable = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; prescale = 6'd8; frame_len = 4'd10;
      test_reset();
      test_frame_8x10();
      test_config_latch();
      test_clamp();
      test_enable_drop();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
